cordic_vectoring: RTL and testbench

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/cordic_vectoring_if.sv | 16 +
 rtl/cordic_atan_lut.sv | 12 +
 rtl/cordic_vectoring.sv | 132 +++++++++++++
 tb/tb_cordic_vectoring.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, default sizes, FSM state encoding.
package cordic_pkg;

   localparam int ITER_DEF = 13;
   localparam int IW_DEF   = 16;
   localparam int IO_W     = 14;
   localparam int MAG_W    = 14;
   localparam int ANG_W    = 16;
   localparam int ATAN_W   = 14;
   localparam int ANG_180  = 18000;
   localparam int MAG_MAX  = 16383;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_SCALE
   } cordic_state_t;

   // atan(2^-i) in 0.01 degree; entries past the useful precision are zero
   localparam logic [ATAN_W-1:0] ATAN_TAB [16] = '{
      14'd4500, 14'd2657, 14'd1404, 14'd713, 14'd358, 14'd179, 14'd90, 14'd45,
      14'd22,   14'd11,   14'd6,    14'd3,   14'd1,   14'd0,   14'd0,  14'd0
   };

endpackage

// File: rtl/cordic_vectoring_if.sv
// Request/result bundle of the vectoring engine.
interface cordic_vectoring_if;
   import cordic_pkg::*;

   logic                    start;
   logic signed [IO_W-1:0]  x_in;
   logic signed [IO_W-1:0]  y_in;
   logic        [MAG_W-1:0] mag_out;
   logic signed [ANG_W-1:0] ang_out;
   logic                    busy;
   logic                    finish;

   modport master (output start, x_in, y_in, input mag_out, ang_out, busy, finish);
   modport slave  (input start, x_in, y_in, output mag_out, ang_out, busy, finish);

endinterface

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup: iteration index -> atan(2^-i) in 0.01 degree.
module cordic_atan_lut
   import cordic_pkg::*;
(
   input  logic [3:0]        idx,
   output logic [ATAN_W-1:0] angle
);

   // table read
   always_comb angle = ATAN_TAB[idx];

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring: (x,y) -> gain-compensated magnitude and atan2 angle.
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int ITER = ITER_DEF,
   parameter int IW   = IW_DEF
)
(
   input logic              clk,
   input logic              rst,
   cordic_vectoring_if.slave bus
);

   localparam logic signed [IW-1:0] ANG_POS = IW'(ANG_180);
   localparam logic signed [IW-1:0] ANG_NEG = -ANG_POS;
   localparam logic signed [IW-1:0] MAG_LIM = IW'(MAG_MAX);

   cordic_state_t           state, state_nx;
   logic [3:0]              cnt;
   logic signed [IW-1:0]    x, y, z;
   logic signed [IW-1:0]    xs, ys, x_ext, y_ext, atan_ext, mag_full;
   logic [ATAN_W-1:0]       atan_val;
   logic [MAG_W-1:0]        mag_sat;
   logic signed [ANG_W-1:0] ang_sat;
   logic                    accept, last_iter, zero_in;

   cordic_atan_lut u_lut (
      .idx   (cnt),
      .angle (atan_val)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // next-state decode; start only counts in IDLE
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      last_iter = (cnt == 4'(ITER - 1));
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = ST_ITER;
            end
         end
         ST_ITER:  if (last_iter) state_nx = ST_SCALE;
         ST_SCALE: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // operand extension, shifted terms, gain compensation and output saturation
   always_comb begin
      x_ext    = {{(IW-IO_W){bus.x_in[IO_W-1]}}, bus.x_in};
      y_ext    = {{(IW-IO_W){bus.y_in[IO_W-1]}}, bus.y_in};
      xs       = x >>> cnt;
      ys       = y >>> cnt;
      atan_ext = {{(IW-ATAN_W){1'b0}}, atan_val};
      mag_full = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9) - (x >>> 12);
      if (mag_full[IW-1])         mag_sat = '0;
      else if (mag_full > MAG_LIM) mag_sat = '1;
      else                         mag_sat = mag_full[MAG_W-1:0];
      if (z > ANG_POS)      ang_sat = ANG_W'(ANG_POS);
      else if (z < ANG_NEG) ang_sat = ANG_W'(ANG_NEG);
      else                  ang_sat = ANG_W'(z);
      // origin has no defined angle; the iterations would still accumulate z
      if (zero_in) begin
         mag_sat = '0;
         ang_sat = '0;
      end
   end

   // datapath: pre-rotate on accept, micro-rotate in ITER, publish in SCALE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         z           <= '0;
         cnt         <= '0;
         zero_in     <= 1'b0;
         bus.mag_out <= '0;
         bus.ang_out <= '0;
         bus.busy    <= 1'b0;
         bus.finish  <= 1'b0;
      end else begin
         bus.finish <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  zero_in  <= (x_ext == '0) && (y_ext == '0);
                  if (!x_ext[IW-1]) begin
                     x <= x_ext;
                     y <= y_ext;
                     z <= '0;
                  end else begin
                     x <= -x_ext;
                     y <= -y_ext;
                     z <= y_ext[IW-1] ? ANG_NEG : ANG_POS;
                  end
               end
            end
            ST_ITER: begin
               if (!y[IW-1]) begin
                  x <= x + ys;
                  y <= y - xs;
                  z <= z + atan_ext;
               end else begin
                  x <= x - ys;
                  y <= y + xs;
                  z <= z - atan_ext;
               end
               cnt <= cnt + 4'd1;
            end
            ST_SCALE: begin
               bus.mag_out <= mag_sat;
               bus.ang_out <= ang_sat;
               bus.finish  <= 1'b1;
               bus.busy    <= 1'b0;
               cnt         <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: vector table, scoreboard, hand-written corner sequences.
module tb_cordic_vectoring;

   localparam int LAT   = 14;
   localparam int MTOL  = 4;
   localparam int ATOL  = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   fin_cnt = 0;
   logic prev_fin = 1'b0;

   cordic_vectoring_if bus();

   cordic_vectoring #(.ITER(13), .IW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    x;
      int    y;
      int    nmag;
      int    nang;
   } vec_t;

   typedef struct {
      int    mag;
      int    ang;
      int    nmag;
      int    nang;
      bit    has_nom;
      int    acc;
      string tag;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[8];
   int   atan_t [0:12] = '{4500, 2657, 1404, 713, 358, 179, 90, 45, 22, 11, 6, 3, 1};

   task automatic check(input string name, input int act, input int exp, input int tol);
      int d;
      d = act - exp;
      if (d < 0) d = -d;
      checks++;
      if (d > tol) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
      end
   endtask

   // reference: micro-rotations on plain integers, then scaling and clamping
   task automatic model(input int xi, input int yi, output int m, output int a);
      int x, y, z, xn;
      if (xi >= 0) begin x = xi; y = yi; z = 0; end
      else begin x = -xi; y = -yi; z = (yi < 0) ? -18000 : 18000; end
      for (int i = 0; i < 13; i++) begin
         if (y >= 0) begin xn = x + (y >>> i); y = y - (x >>> i); z = z + atan_t[i]; end
         else        begin xn = x - (y >>> i); y = y + (x >>> i); z = z - atan_t[i]; end
         x = xn;
      end
      m = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9) - (x >>> 12);
      if (m < 0) m = 0;
      if (m > 16383) m = 16383;
      a = (z > 18000) ? 18000 : ((z < -18000) ? -18000 : z);
      if (xi == 0 && yi == 0) begin m = 0; a = 0; end
   endtask

   task automatic push(input int xi, input int yi, input int acc, input bit nom,
                       input int nm, input int na, input string tag);
      sb_t e;
      model(xi, yi, e.mag, e.ang);
      e.nmag = nm; e.nang = na; e.has_nom = nom; e.acc = acc; e.tag = tag;
      sb.push_back(e);
   endtask

   // result monitor
   always @(negedge clk) begin
      if (prev_fin) check("finish_width", int'(bus.finish), 0, 0);
      prev_fin = bus.finish;
      if (bus.finish) begin
         fin_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_finish", 1, 0, 0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check({e.tag, "_mag"}, int'(bus.mag_out), e.mag, 0);
            check({e.tag, "_ang"}, int'(bus.ang_out), e.ang, 0);
            check({e.tag, "_latency"}, cyc - e.acc, LAT, 0);
            if (e.has_nom) begin
               check({e.tag, "_mag_nominal"}, int'(bus.mag_out), e.nmag, MTOL);
               check({e.tag, "_ang_nominal"}, int'(bus.ang_out), e.nang, ATOL);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 100) begin @(negedge clk); n++; end
      if (bus.busy) check("idle_timeout", 1, 0, 0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         check("finish_timeout", sb.size(), 0, 0);
         sb.delete();
      end
   endtask

   // one start pulse; returns on the negedge after the accept edge
   task automatic start_op(input int xi, input int yi, input bit nom, input int nm,
                           input int na, input string tag);
      wait_idle();
      bus.x_in  = 14'(xi);
      bus.y_in  = 14'(yi);
      bus.start = 1'b1;
      push(xi, yi, cyc + 1, nom, nm, na, tag);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int f0, acc0;
      bus.start = 1'b0;
      bus.x_in  = '0;
      bus.y_in  = '0;
      vecs[0] = '{1000, 0, 1000, 0};
      vecs[1] = '{1000, 1000, 1414, 4500};
      vecs[2] = '{0, 2000, 2000, 9000};
      vecs[3] = '{-1000, 0, 1000, 18000};
      vecs[4] = '{-1000, -1000, 1414, -13500};
      vecs[5] = '{-8192, -8192, 11585, -13500};
      vecs[6] = '{0, 0, 0, 0};
      vecs[7] = '{3000, -4000, 5000, -5313};

      repeat (3) @(negedge clk);
      check("rst_mag", int'(bus.mag_out), 0, 0);
      check("rst_ang", int'(bus.ang_out), 0, 0);
      check("rst_busy", int'(bus.busy), 0, 0);
      check("rst_finish", int'(bus.finish), 0, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         start_op(vecs[i].x, vecs[i].y, 1'b1, vecs[i].nmag, vecs[i].nang, $sformatf("vec%0d", i));
         wait_done();
      end

      for (int i = 0; i < 8; i++) begin
         start_op($urandom_range(16383) - 8192, $urandom_range(16383) - 8192, 1'b0, 0, 0,
                  $sformatf("rnd%0d", i));
      end
      wait_done();

      // starts while busy and in the SCALE cycle, with input changes after accept
      f0 = fin_cnt;
      start_op(1234, -567, 1'b0, 0, 0, "busy_start");
      for (int k = 0; k < 14; k++) begin
         if (k < 13) check("busy_held", int'(bus.busy), 1, 0);
         bus.start = (k == 3 || k == 5 || k == 13);
         bus.x_in  = 14'(-3000 + k);
         bus.y_in  = 14'(2500 - k);
         @(negedge clk);
      end
      bus.start = 1'b0;
      wait_done();
      repeat (20) @(negedge clk);
      check("busy_start_finish_count", fin_cnt - f0, 1, 0);

      // asynchronous abort partway through the iterations
      start_op(5000, 3000, 1'b0, 0, 0, "abort");
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      sb.delete();
      f0 = fin_cnt;
      check("abort_mag", int'(bus.mag_out), 0, 0);
      check("abort_ang", int'(bus.ang_out), 0, 0);
      check("abort_busy", int'(bus.busy), 0, 0);
      check("abort_finish", int'(bus.finish), 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_no_finish", fin_cnt - f0, 0, 0);
      start_op(0, 0, 1'b1, 0, 0, "post_abort_zero");
      wait_done();

      // start held high across three operations
      wait_idle();
      f0 = fin_cnt;
      bus.x_in  = 14'(-2500);
      bus.y_in  = 14'(1200);
      bus.start = 1'b1;
      acc0 = cyc + 1;
      push(-2500, 1200, acc0, 1'b0, 0, 0, "held0");
      @(negedge clk);
      bus.x_in = 14'(4000);
      bus.y_in = 14'(-7000);
      push(4000, -7000, acc0 + 15, 1'b0, 0, 0, "held1");
      repeat (15) @(negedge clk);
      bus.x_in = 14'(-6000);
      bus.y_in = 14'(-500);
      push(-6000, -500, acc0 + 30, 1'b0, 0, 0, "held2");
      repeat (15) @(negedge clk);
      bus.start = 1'b0;
      bus.x_in  = 14'(777);
      bus.y_in  = 14'(-777);
      wait_done();
      repeat (20) @(negedge clk);
      check("held_finish_count", fin_cnt - f0, 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
